// File: rtl/hwpe_stream_package.sv
// Shared types for the realigner family: per-word realign control, the
// address-generator descriptor and the address-generator FSM states.
package hwpe_stream_package;

   // Field widths of the shared structs. Module parameters that feed them
   // (ADDR_WIDTH, CNT_WIDTH) must not exceed these.
   localparam int unsigned REALIGN_LEN_W  = 16;
   localparam int unsigned ADDRGEN_ADDR_W = 32;
   localparam int unsigned ADDRGEN_CNT_W  = 16;

   typedef struct packed {
      logic                     enable;
      logic                     realign;
      logic                     first;
      logic                     last;
      logic                     last_packet;
      logic [REALIGN_LEN_W-1:0] line_length;
   } ctrl_realign_t;

   typedef struct packed {
      logic [ADDRGEN_ADDR_W-1:0] base;
      logic [ADDRGEN_CNT_W-1:0]  length;
      logic [ADDRGEN_ADDR_W-1:0] stride;
      logic [ADDRGEN_CNT_W-1:0]  nb_lines;
   } addrgen_cfg_t;

   typedef enum logic [1:0] {
      ADDRGEN_IDLE = 2'd0,
      ADDRGEN_RUN  = 2'd1,
      ADDRGEN_DONE = 2'd2
   } addrgen_state_t;

   // Mask that clears the byte-offset bits of an address.
   function automatic logic [ADDRGEN_ADDR_W-1:0] addrgen_align_mask(input int unsigned offw);
      logic [ADDRGEN_ADDR_W-1:0] ones;
      ones = '1;
      return ones << offw;
   endfunction

endpackage

// File: rtl/hwpe_stream_realign_strbgen.sv
// Byte-strobe generator for a realigned line: the first word keeps the bytes
// at and above the offset, the last word keeps the bytes below it, everything
// else (and any non-realigned word) is fully enabled.
module hwpe_stream_realign_strbgen
#(
   parameter int unsigned BW   = 4,
   parameter int unsigned OFFW = $clog2(BW)
)
(
   input  logic [OFFW-1:0] i_off,
   input  logic            i_first,
   input  logic            i_last,
   input  logic            i_realign,
   output logic [BW-1:0]   o_strb
);

   generate
      for (genvar gi = 0; gi < BW; gi++) begin : g_byte
         logic w_upper;
         assign w_upper = (OFFW'(gi) >= i_off);
         assign o_strb[gi] = ~i_realign          ? 1'b1    :
                             i_first             ? w_upper :
                             i_last              ? ~w_upper :
                                                   1'b1;
      end
   endgenerate

endmodule

// File: rtl/hwpe_stream_realign_addrgen.sv
// Word-aligned TCDM load-address generator for a byte-granular 2D descriptor.
// Each issued address carries the ctrl_realign_t fields and byte strobes the
// source realigner needs; a misaligned base adds one word per line.
// Optional output register + skid buffer: define HWPE_ADDRGEN_OUT_REG_EN.
module hwpe_stream_realign_addrgen
   import hwpe_stream_package::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [CNT_WIDTH-1:0]  line_length_i,
   input  logic [ADDR_WIDTH-1:0] line_stride_i,
   input  logic [CNT_WIDTH-1:0]  nb_lines_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  addr_valid_o,
   input  logic                  addr_ready_i,
   output ctrl_realign_t         ctrl_o,
   output logic [DATA_WIDTH/8-1:0] strb_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned BW   = DATA_WIDTH / 8;
   localparam int unsigned OFFW = $clog2(BW);
   localparam int unsigned AW   = ADDRGEN_ADDR_W;
   localparam int unsigned CW   = ADDRGEN_CNT_W;
   localparam logic [AW-1:0] ALIGN_MASK = addrgen_align_mask(OFFW);

   // Descriptor and iteration state. r_cfg.base tracks the byte address of
   // the current line start (offset bits included); r_addr is the word
   // address being offered.
   addrgen_state_t r_state;
   addrgen_cfg_t   r_cfg;
   logic           r_realign;
   logic [CW:0]    r_words_per_line;
   logic [CW:0]    r_word_cnt;
   logic [CW-1:0]  r_line_cnt;
   logic [AW-1:0]  r_addr;
   logic           r_busy;
   logic           r_done;

   logic [OFFW-1:0] w_start_off;
   logic            w_start_realign;
   logic            w_start_empty;
   logic            w_core_valid;
   logic            w_core_ready;
   logic            w_hs;
   logic            w_first;
   logic            w_last;
   logic            w_last_line;
   logic [AW-1:0]   w_next_line;
   logic [ADDR_WIDTH-1:0] w_core_addr;
   ctrl_realign_t   w_core_ctrl;
   logic [BW-1:0]   w_core_strb;

   assign w_start_off     = base_addr_i[OFFW-1:0];
   assign w_start_realign = |w_start_off;
   assign w_start_empty   = (line_length_i == '0) || (nb_lines_i == '0);

   assign w_core_valid = (r_state == ADDRGEN_RUN);
   assign w_hs         = w_core_valid & w_core_ready;
   assign w_first      = (r_word_cnt == '0);
   assign w_last       = (r_word_cnt == r_words_per_line - (CW+1)'(1));
   assign w_last_line  = (r_line_cnt == r_cfg.nb_lines - CW'(1));
   // Stride is stored with its offset bits cleared, so the line offset is
   // preserved across lines.
   assign w_next_line  = r_cfg.base + r_cfg.stride;

   // Control FSM with descriptor latch, word/line counters and status flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state          <= ADDRGEN_IDLE;
         r_cfg            <= '0;
         r_realign        <= 1'b0;
         r_words_per_line <= '0;
         r_word_cnt       <= '0;
         r_line_cnt       <= '0;
         r_addr           <= '0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
      end else if (clear_i) begin
         r_state    <= ADDRGEN_IDLE;
         r_word_cnt <= '0;
         r_line_cnt <= '0;
         r_addr     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ADDRGEN_IDLE: begin
               r_done <= 1'b0;
               if (start_i) begin
                  r_cfg.base       <= AW'(base_addr_i);
                  r_cfg.length     <= CW'(line_length_i);
                  r_cfg.stride     <= AW'(line_stride_i) & ALIGN_MASK;
                  r_cfg.nb_lines   <= CW'(nb_lines_i);
                  r_realign        <= w_start_realign;
                  r_words_per_line <= (CW+1)'(line_length_i) + (CW+1)'(w_start_realign);
                  r_word_cnt       <= '0;
                  r_line_cnt       <= '0;
                  r_addr           <= AW'(base_addr_i) & ALIGN_MASK;
                  if (w_start_empty) begin
                     r_state <= ADDRGEN_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ADDRGEN_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ADDRGEN_RUN: begin
               if (w_hs) begin
                  if (w_last) begin
                     r_word_cnt <= '0;
                     if (w_last_line) begin
                        r_state <= ADDRGEN_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_line_cnt <= r_line_cnt + CW'(1);
                        r_cfg.base <= w_next_line;
                        r_addr     <= w_next_line & ALIGN_MASK;
                     end
                  end else begin
                     r_word_cnt <= r_word_cnt + (CW+1)'(1);
                     r_addr     <= r_addr + AW'(BW);
                  end
               end
            end
            ADDRGEN_DONE: begin
               r_done  <= 1'b0;
               r_state <= ADDRGEN_IDLE;
            end
            default: begin
               r_state <= ADDRGEN_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Per-word control fields; all zero outside RUN.
   always_comb begin
      w_core_ctrl = '0;
      if (w_core_valid) begin
         w_core_ctrl.enable      = r_busy;
         w_core_ctrl.realign     = r_realign;
         w_core_ctrl.first       = w_first;
         w_core_ctrl.last        = w_last;
         w_core_ctrl.last_packet = w_last & w_last_line;
         w_core_ctrl.line_length = REALIGN_LEN_W'(r_cfg.length);
      end
   end

   assign w_core_addr = w_core_valid ? ADDR_WIDTH'(r_addr) : '0;

   hwpe_stream_realign_strbgen #(
      .BW   ( BW   ),
      .OFFW ( OFFW )
   ) i_strbgen (
      .i_off     ( r_cfg.base[OFFW-1:0]     ),
      .i_first   ( w_first                  ),
      .i_last    ( w_last                   ),
      .i_realign ( r_realign & w_core_valid ),
      .o_strb    ( w_core_strb              )
   );

   assign busy_o = r_busy;
   assign done_o = r_done;

`ifdef HWPE_ADDRGEN_OUT_REG_EN
   // Registered output: one output entry plus a skid entry. Upstream ready is
   // the registered skid-empty flag, so addr_ready_i reaches no output
   // combinationally. done_o marks the last word entering this stage.
   localparam int unsigned PW = ADDR_WIDTH + $bits(ctrl_realign_t) + BW;
   localparam logic [PW-1:0] IDLE_PAYLOAD = {{(PW-BW){1'b0}}, {BW{1'b1}}};

   logic [PW-1:0] w_core_payload;
   logic [PW-1:0] r_out_payload;
   logic [PW-1:0] r_skid_payload;
   logic          r_out_valid;
   logic          r_skid_valid;
   logic          w_up_xfer;
   logic          w_out_free;

   assign w_core_payload = {w_core_addr, w_core_ctrl, w_core_strb};
   assign w_core_ready   = ~r_skid_valid;
   assign w_up_xfer      = w_core_valid & ~r_skid_valid;
   assign w_out_free     = ~r_out_valid | addr_ready_i;

   // Output/skid register pair: the skid entry drains first, otherwise the
   // output entry loads straight from the generator.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_out_valid    <= 1'b0;
         r_out_payload  <= IDLE_PAYLOAD;
         r_skid_valid   <= 1'b0;
         r_skid_payload <= IDLE_PAYLOAD;
      end else if (clear_i) begin
         r_out_valid    <= 1'b0;
         r_out_payload  <= IDLE_PAYLOAD;
         r_skid_valid   <= 1'b0;
         r_skid_payload <= IDLE_PAYLOAD;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_out_valid   <= 1'b1;
            r_out_payload <= r_skid_payload;
            r_skid_valid  <= 1'b0;
         end else begin
            r_out_valid   <= w_up_xfer;
            r_out_payload <= w_core_payload;
         end
      end else if (w_up_xfer) begin
         r_skid_valid   <= 1'b1;
         r_skid_payload <= w_core_payload;
      end
   end

   assign {addr_o, ctrl_o, strb_o} = r_out_payload;
   assign addr_valid_o             = r_out_valid;
`else
   // Outputs straight from the counters: first address one cycle after start.
   assign w_core_ready = addr_ready_i;
   assign addr_o       = w_core_addr;
   assign addr_valid_o = w_core_valid;
   assign ctrl_o       = w_core_ctrl;
   assign strb_o       = w_core_strb;
`endif

endmodule

// File: doc/hwpe_stream_realign_addrgen.md
Name: hwpe_stream_realign_addrgen

Overview:
Upstream partner of the source realigner: turns a byte-granular 2D access descriptor into word-aligned TCDM load addresses.
Each address is paired with the per-word ctrl_realign_t fields and byte strobes that the realigner consumes.
When the base address is misaligned, each line issues one extra word.
Intended pairing: realigner instantiated with DECOUPLED=1, so ctrl/strb are aligned to the address handshake, not to data return.

Parameters:
DATA_WIDTH, 32, stream/TCDM word width in bits; BW = DATA_WIDTH/8, OFFW = $clog2(BW)
ADDR_WIDTH, 32, byte address width
CNT_WIDTH, 16, width of line_length and nb_lines counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous soft clear: state to IDLE, counters zeroed
start_i  in  1  one-cycle pulse; sampled only in IDLE
base_addr_i  in  ADDR_WIDTH  first byte address
line_length_i  in  CNT_WIDTH  payload words per line
line_stride_i  in  ADDR_WIDTH  byte stride between line starts (two's complement)
nb_lines_i  in  CNT_WIDTH  number of lines
addr_o  out  ADDR_WIDTH  word-aligned load address
addr_valid_o  out  1  address valid
addr_ready_i  in  1  address accepted
ctrl_o  out  ctrl_realign_t  enable/realign/first/last/last_packet/line_length for the current word
strb_o  out  BW  byte strobe for the current word
busy_o  out  1  high in RUN
done_o  out  1  one-cycle pulse at completion

Behaviour:
- Reset / clear outputs: addr_o=0, addr_valid_o=0, ctrl_o all fields 0, strb_o='1, busy_o=0, done_o=0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE, on start_i:
  - latch descriptor; off = base_addr_i[OFFW-1:0]; realign = (off != 0).
  - line_base = base_addr_i with low OFFW bits cleared.
  - words_per_line = line_length_i + realign.
  - if line_length_i==0 or nb_lines_i==0: go to DONE, no address issued; else go to RUN.
- RUN:
  - addr_valid_o=1; addr_o = line_base + word_cnt*BW.
  - advance only on addr_valid_o & addr_ready_i; hold all outputs while stalled.
- Per-word fields:
  - first = (word_cnt==0); last = (word_cnt==words_per_line-1).
  - last_packet = last & (line_cnt==nb_lines-1).
  - ctrl_o.realign = realign; ctrl_o.line_length = line_length_i; ctrl_o.enable = busy.
- Strobes: not realign -> '1. Realign -> first: '1<<off; last: ~('1<<off); middle: '1.
- Counter wrap on last-word handshake: word_cnt->0, line_cnt++, line_base += line_stride_i, with the low OFFW bits of the stride ignored.
- Handshake on the last_packet word: go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. Descriptor registers hold until the next start.
- start_i outside IDLE is ignored.
- clear_i has priority over start_i and over any handshake in the same cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Single misaligned word (line_length=1): two accesses, first and last, no middle.

Optional Feature:
Macro HWPE_ADDRGEN_OUT_REG_EN.
- Defined: addr_o/addr_valid_o/ctrl_o/strb_o come from a one-entry output register plus skid buffer.
  - First address appears 2 cycles after start_i.
  - Full throughput is preserved.
  - addr_ready_i has no combinational path to any output.
- Undefined: outputs are combinational from the counters. First address 1 cycle after start_i.
- The address sequence is identical in both cases.

Decomposition:
- Package hwpe_stream_package: existing ctrl_realign_t; add addrgen_cfg_t (base, length, stride, nb_lines) and addrgen_state_t enum.
- Sub-module hwpe_stream_realign_strbgen: combinational (off, first, last, realign) -> strb. Shared with the sink-side realigner.

Test Plan:
- Aligned case, base=0x100, len=3, lines=1, always ready -> addrs 0x100/0x104/0x108. Strb all 0xF. first on word 0, last/last_packet on word 2. done 1 cycle later.
- Misaligned case, base=0x102, len=2, lines=1 -> addrs 0x100/0x104/0x108. Strb 0xC/0xF/0x3. realign=1.
- 2D case, base=0x201, len=1, stride=0x40, lines=2 -> addrs 0x200, 0x204, 0x240, 0x244. first/last per line; last_packet only on 0x244.
- Backpressure: random addr_ready_i deasserts -> outputs stable while stalled. Sequence identical to the always-ready run.
- Zero lines or zero length (nb_lines=0 or len=0) -> no addr_valid_o. done_o pulses once.
- clear_i asserted mid-RUN -> next cycle IDLE, addr_valid_o=0, no done_o. A new start_i replays from the base address.
